ysyx_22050612_lsu: RTL and testbench

Multi-cycle load/store unit sitting directly downstream of the execute stage. It takes one memory request per transaction: effective address from the ALU, store data from rs2, access size and signedness. It then performs a single aligned 64-bit access on the data-memory handshake bus. For loads it returns the extracted, sign/zero-extended 64-bit writeback value; stores complete on handshake.

---
 rtl/ysyx_22050612_lsu.sv | 170 +++++++++++++++++
 tb/tb_ysyx_22050612_lsu.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/ysyx_22050612_lsu.sv
// Multi-cycle load/store unit: one aligned 64-bit data-memory access per request,
// with byte-lane store steering and sign/zero-extending load extraction.
module ysyx_22050612_lsu #(
    parameter int XLEN = 64
) (
    input  logic            i_clk,
    input  logic            i_rst,
    // request from execute
    input  logic            i_req_valid,
    output logic            o_req_ready,
    input  logic            i_req_wen,
    input  logic [XLEN-1:0] i_req_addr,
    input  logic [XLEN-1:0] i_req_wdata,
    input  logic [1:0]      i_req_size,
    input  logic            i_req_unsigned,
    input  logic [4:0]      i_req_rd,
    // data-memory bus
    output logic            o_mem_valid,
    input  logic            i_mem_ready,
    output logic            o_mem_wen,
    output logic [XLEN-1:0] o_mem_addr,
    output logic [XLEN-1:0] o_mem_wdata,
    output logic [7:0]      o_mem_wmask,
    input  logic            i_mem_rvalid,
    input  logic [XLEN-1:0] i_mem_rdata,
    // response to writeback
    output logic            o_resp_valid,
    output logic [XLEN-1:0] o_resp_rdata,
    output logic [4:0]      o_resp_rd,
    output logic            o_resp_err
);

    localparam int NUM_LANES = 8;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t r_state, w_next;

    logic [2:0]            w_off;
    logic [3:0]            w_nbytes;
    logic [3:0]            w_lane_end;
    logic                  w_misaligned;
    logic [NUM_LANES-1:0]  w_wmask;
    logic [XLEN-1:0]       w_wdata;
    logic [XLEN-1:0]       w_shifted;
    logic [XLEN-1:0]       w_ld;

    logic                  r_mem_wen;
    logic [XLEN-1:0]       r_mem_addr;
    logic [XLEN-1:0]       r_mem_wdata;
    logic [NUM_LANES-1:0]  r_mem_wmask;
    logic [2:0]            r_off;
    logic [1:0]            r_size;
    logic                  r_unsigned;
    logic [XLEN-1:0]       r_resp_rdata;
    logic [4:0]            r_resp_rd;
    logic                  r_resp_err;

    // ---------------- request decode (used only at acceptance) ----------------
    assign w_off = i_req_addr[2:0];

    always_comb begin
        w_nbytes     = 4'd1;
        w_misaligned = 1'b0;
        case (i_req_size)
            2'd0: begin w_nbytes = 4'd1; w_misaligned = 1'b0;              end
            2'd1: begin w_nbytes = 4'd2; w_misaligned = i_req_addr[0];     end
            2'd2: begin w_nbytes = 4'd4; w_misaligned = |i_req_addr[1:0];  end
            default: begin w_nbytes = 4'd8; w_misaligned = |i_req_addr[2:0]; end
        endcase
    end

    assign w_lane_end = {1'b0, w_off} + w_nbytes;

    // A lane is written when it falls inside [off, off + bytes); loads write nothing.
    for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
        assign w_wmask[l] = i_req_wen & (4'(l) >= {1'b0, w_off}) & (4'(l) < w_lane_end);
    end

    assign w_wdata = i_req_wdata << {w_off, 3'b000};

    // ---------------- load extraction (uses latched request fields) ----------------
    assign w_shifted = i_mem_rdata >> {r_off, 3'b000};

    always_comb begin
        w_ld = w_shifted;
        case (r_size)
            2'd0:    w_ld = {{56{~r_unsigned & w_shifted[7]}},  w_shifted[7:0]};
            2'd1:    w_ld = {{48{~r_unsigned & w_shifted[15]}}, w_shifted[15:0]};
            2'd2:    w_ld = {{32{~r_unsigned & w_shifted[31]}}, w_shifted[31:0]};
            default: w_ld = w_shifted;
        endcase
    end

    // ---------------- FSM ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) r_state <= S_IDLE;
        else       r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_req_valid) w_next = w_misaligned ? S_RESP : S_REQ;
            S_REQ:  if (i_mem_ready) w_next = r_mem_wen ? S_RESP : S_WAIT;
            S_WAIT: if (i_mem_rvalid) w_next = S_RESP;
            S_RESP: w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // ---------------- datapath registers ----------------
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_mem_wen    <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_mem_wmask  <= '0;
            r_off        <= '0;
            r_size       <= '0;
            r_unsigned   <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_rd    <= '0;
            r_resp_err   <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_req_valid) begin
                        r_mem_wen    <= i_req_wen;
                        r_mem_addr   <= {i_req_addr[XLEN-1:3], 3'b000};
                        r_mem_wdata  <= w_wdata;
                        r_mem_wmask  <= w_wmask;
                        r_off        <= w_off;
                        r_size       <= i_req_size;
                        r_unsigned   <= i_req_unsigned;
                        r_resp_rd    <= i_req_rd;
                        r_resp_err   <= w_misaligned;
                        r_resp_rdata <= '0;
                    end
                end
                S_WAIT: begin
                    if (i_mem_rvalid) r_resp_rdata <= w_ld;
                end
                S_RESP: begin
                    // error flag is only meaningful alongside resp_valid
                    r_resp_err <= 1'b0;
                end
                default: ;
            endcase
        end
    end

    // ---------------- outputs: registers or state decode only ----------------
    assign o_req_ready  = (r_state == S_IDLE);
    assign o_mem_valid  = (r_state == S_REQ);
    assign o_resp_valid = (r_state == S_RESP);
    assign o_mem_wen    = r_mem_wen;
    assign o_mem_addr   = r_mem_addr;
    assign o_mem_wdata  = r_mem_wdata;
    assign o_mem_wmask  = r_mem_wmask;
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_rd    = r_resp_rd;
    assign o_resp_err   = r_resp_err;

endmodule

// File: tb/tb_ysyx_22050612_lsu.sv
// Self-checking bench for ysyx_22050612_lsu: directed plus random transactions
// checked cycle-by-cycle against a byte-level reference model.
module tb_ysyx_22050612_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_wen;
    logic [63:0] req_addr;
    logic [63:0] req_wdata;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [4:0]  req_rd;
    logic        mem_valid;
    logic        mem_ready;
    logic        mem_wen;
    logic [63:0] mem_addr;
    logic [63:0] mem_wdata;
    logic [7:0]  mem_wmask;
    logic        mem_rvalid;
    logic [63:0] mem_rdata;
    logic        resp_valid;
    logic [63:0] resp_rdata;
    logic [4:0]  resp_rd;
    logic        resp_err;

    int n_chk  = 0;
    int n_fail = 0;

    ysyx_22050612_lsu #(.XLEN(64)) dut (
        .i_clk          (clk),
        .i_rst          (rst),
        .i_req_valid    (req_valid),
        .o_req_ready    (req_ready),
        .i_req_wen      (req_wen),
        .i_req_addr     (req_addr),
        .i_req_wdata    (req_wdata),
        .i_req_size     (req_size),
        .i_req_unsigned (req_unsigned),
        .i_req_rd       (req_rd),
        .o_mem_valid    (mem_valid),
        .i_mem_ready    (mem_ready),
        .o_mem_wen      (mem_wen),
        .o_mem_addr     (mem_addr),
        .o_mem_wdata    (mem_wdata),
        .o_mem_wmask    (mem_wmask),
        .i_mem_rvalid   (mem_rvalid),
        .i_mem_rdata    (mem_rdata),
        .o_resp_valid   (resp_valid),
        .o_resp_rdata   (resp_rdata),
        .o_resp_rd      (resp_rd),
        .o_resp_err     (resp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] byte_of(input logic [63:0] v, input int i);
        logic [63:0] t;
        t = v / (64'd1 << (8 * i));
        return t[7:0];
    endfunction

    // Load value: gather the accessed bytes, then sign-extend arithmetically.
    function automatic logic [63:0] m_load(input logic [63:0] rd, input logic [63:0] a,
                                           input int n, input logic uns);
        logic [63:0] v;
        int off;
        off = int'(a % 8);
        v = 0;
        for (int i = 0; i < n; i++) v = v + ({56'd0, byte_of(rd, off + i)} << (8 * i));
        if (!uns && n < 8 && v >= (64'd1 << (8 * n - 1))) v = v - (64'd1 << (8 * n));
        return v;
    endfunction

    function automatic logic [7:0] m_mask(input logic [63:0] a, input int n);
        logic [7:0] m;
        int off;
        off = int'(a % 8);
        m = 0;
        for (int i = 0; i < n; i++) if (off + i < 8) m[off + i] = 1'b1;
        return m;
    endfunction

    function automatic logic [63:0] m_wdata(input logic [63:0] wd, input logic [63:0] a);
        logic [63:0] v;
        int off;
        off = int'(a % 8);
        v = 0;
        for (int i = 0; i < 8; i++)
            if (i >= off) v = v + ({56'd0, byte_of(wd, i - off)} << (8 * i));
        return v;
    endfunction

    // One full transaction. rdly = cycles mem_ready stays low, vdly = extra WAIT cycles.
    task automatic txn(input logic wen, input logic [63:0] a, input logic [63:0] wd,
                       input logic [1:0] sz, input logic uns, input logic [4:0] rd,
                       input logic [63:0] rdat, input int rdly, input int vdly);
        int n, hs, rv, er;
        bit mis;
        logic [63:0] exp_rdata;
        n   = 1 << sz;
        mis = (a % n) != 0;
        hs  = rdly + 1;
        rv  = hs + 1 + vdly;
        er  = mis ? 1 : (wen ? hs + 1 : rv + 1);
        exp_rdata = (mis || wen) ? 64'd0 : m_load(rdat, a, n, uns);

        @(negedge clk);
        chk("req_ready_idle", req_ready, 1);
        req_valid = 1; req_wen = wen; req_addr = a; req_wdata = wd;
        req_size = sz; req_unsigned = uns; req_rd = rd;
        mem_ready = 0; mem_rvalid = 0;

        for (int c = 1; c <= er; c++) begin
            @(negedge clk);
            if (c == 1) begin
                req_valid = 0;
                req_wen = $urandom; req_addr = {$urandom, $urandom}; req_wdata = {$urandom, $urandom};
                req_size = 2'($urandom); req_unsigned = $urandom; req_rd = 5'($urandom);
            end
            chk("resp_valid", resp_valid, 64'(c == er));
            chk("req_ready_busy", req_ready, 0);
            chk("mem_valid", mem_valid, 64'(!mis && c <= hs));
            if (!mis && c <= hs) begin
                chk("mem_wen", mem_wen, 64'(wen));
                chk("mem_addr", mem_addr, {a[63:3], 3'b000});
                chk("mem_wmask", mem_wmask, wen ? 64'(m_mask(a, n)) : 64'd0);
                if (wen) chk("mem_wdata", mem_wdata, m_wdata(wd, a));
            end
            if (c == er) begin
                chk("resp_rdata", resp_rdata, exp_rdata);
                chk("resp_rd", resp_rd, 64'(rd));
                chk("resp_err", resp_err, 64'(mis));
            end
            // rvalid with junk data at the handshake cycle must be ignored
            mem_ready  = !mis && (c == hs);
            mem_rvalid = (c == rv) || (c == hs);
            mem_rdata  = (c == rv) ? rdat : {$urandom, $urandom};
        end
    endtask

    initial begin
        logic [63:0] a;
        logic [1:0]  sz;
        rst = 1; req_valid = 0; req_wen = 0; req_addr = 0; req_wdata = 0;
        req_size = 0; req_unsigned = 0; req_rd = 0;
        mem_ready = 0; mem_rvalid = 0; mem_rdata = 0;

        @(posedge clk);
        @(negedge clk);
        chk("rst_req_ready", req_ready, 1);
        chk("rst_mem_valid", mem_valid, 0);
        chk("rst_mem_wen", mem_wen, 0);
        chk("rst_mem_wmask", mem_wmask, 0);
        chk("rst_mem_addr", mem_addr, 0);
        chk("rst_mem_wdata", mem_wdata, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_rdata", resp_rdata, 0);
        chk("rst_resp_rd", resp_rd, 0);
        rst = 0;
        // stale rvalid in IDLE right after reset
        mem_rvalid = 1; mem_rdata = 64'hDEAD_BEEF_DEAD_BEEF;
        @(negedge clk);
        mem_rvalid = 0;
        chk("stale_rvalid_resp", resp_valid, 0);
        chk("stale_rvalid_ready", req_ready, 1);

        // directed
        txn(0, 64'h8000_0005, 0, 2'd0, 0, 5'd7, 64'h0000_8000_0000_0000, 0, 0);
        chk("ld_byte_const", resp_rdata, 64'hFFFF_FFFF_FFFF_FF80);
        txn(0, 64'h8000_0006, 0, 2'd1, 1, 5'd9, 64'hBEEF_0000_0000_0000, 0, 0);
        chk("ld_half_const", resp_rdata, 64'h0000_0000_0000_BEEF);
        txn(1, 64'h8000_0005, 64'hAB, 2'd0, 0, 5'd3, 0, 0, 0);
        txn(1, 64'h8000_0010, 64'h0123_4567_89AB_CDEF, 2'd3, 0, 5'd4, 0, 0, 0);
        txn(0, 64'h8000_0002, 0, 2'd2, 0, 5'd5, 64'h1111_2222_3333_4444, 0, 0);
        txn(1, 64'h8000_0020, 64'hCAFE_F00D, 2'd2, 0, 5'd6, 0, 3, 0);
        txn(0, 64'h8000_0024, 0, 2'd2, 0, 5'd8, 64'h8765_4321_0000_0000, 2, 3);
        txn(0, 64'h8000_0028, 0, 2'd3, 1, 5'd1, 64'hF00D_CAFE_1234_5678, 0, 1);

        // reset while in WAIT, then a late rvalid
        @(negedge clk);
        req_valid = 1; req_wen = 0; req_addr = 64'h8000_0040; req_size = 2'd3; req_rd = 5'd11;
        @(negedge clk);
        req_valid = 0; mem_ready = 1;
        @(negedge clk);
        mem_ready = 0; rst = 1;
        @(negedge clk);
        rst = 0;
        chk("rstw_mem_valid", mem_valid, 0);
        chk("rstw_req_ready", req_ready, 1);
        chk("rstw_resp_err", resp_err, 0);
        mem_rvalid = 1; mem_rdata = 64'h5555_AAAA_5555_AAAA;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            mem_rvalid = 0;
            chk("rstw_no_resp", resp_valid, 0);
            chk("rstw_ready", req_ready, 1);
        end

        // random
        for (int i = 0; i < 60; i++) begin
            sz = 2'($urandom);
            a  = {32'h0, 32'h8000_0000 + ($urandom & 32'h0000_FFF8)};
            if ($urandom_range(0, 4) == 0) a = a + 64'($urandom_range(0, 7));
            else a = a + 64'(($urandom_range(0, 7) >> sz) << sz);
            txn($urandom, a, {$urandom, $urandom}, sz, $urandom, 5'($urandom),
                {$urandom, $urandom}, $urandom_range(0, 3), $urandom_range(0, 3));
        end

        @(negedge clk);
        chk("final_ready", req_ready, 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
